// File: rtl/tx_frame_timer.sv
// tx_frame_timer: transmit-side OFDM frame timing generator.
// Walks a (symbol, sample) position through each frame, one step per accepted
// sample, and decodes the framing markers from that registered position.
// Frames repeat until a stop request, with an optional idle gap between frames.
module tx_frame_timer #(
  parameter int N_symb  = 50,
  parameter int fftsize = 1024,
  parameter int cpsize  = 32,
  parameter int gap_len = 0,
  localparam int N_spfr = fftsize + cpsize,
  localparam int SYM_W  = (N_symb > 1) ? $clog2(N_symb) : 1,
  localparam int SAMP_W = $clog2(N_spfr)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              iready,
  output logic              ovalid,
  output logic              osop,
  output logic              osos,
  output logic              ocp,
  output logic              oeop,
  output logic [SYM_W-1:0]  sym_idx,
  output logic [SAMP_W-1:0] samp_idx,
  output logic [15:0]       frame_cnt,
  output logic              busy
);

  localparam int GAP_W = (gap_len > 1) ? $clog2(gap_len) : 1;

  localparam logic [SAMP_W-1:0] SAMP_LAST = SAMP_W'(N_spfr - 1);
  localparam logic [SYM_W-1:0]  SYM_LAST  = SYM_W'(N_symb - 1);
  localparam logic [SAMP_W-1:0] CP_LEN    = SAMP_W'(cpsize);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((gap_len > 0) ? gap_len - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t              r_state;
  logic [SYM_W-1:0]    r_sym_idx;
  logic [SAMP_W-1:0]   r_samp_idx;
  logic [15:0]         r_frame_cnt;
  logic [GAP_W-1:0]    r_gap_cnt;
  logic                r_stop_pend;

  logic w_run;
  logic w_xfer;
  logic w_last_samp;
  logic w_last_sym;

  assign w_run       = (r_state == ST_RUN);
  assign w_xfer      = w_run && iready;
  assign w_last_samp = (r_samp_idx == SAMP_LAST);
  assign w_last_sym  = (r_sym_idx == SYM_LAST);

  // Frame state machine: position counters advance only on an accepted sample.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; a later assignment in the block overrides an
  // earlier one, which is how entry to IDLE wins over setting stop_pend.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_sym_idx   <= '0;
      r_samp_idx  <= '0;
      r_frame_cnt <= '0;
      r_gap_cnt   <= '0;
      r_stop_pend <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // stop is not latched here; start wins when both are high.
          if (start) begin
            r_state     <= ST_RUN;
            r_sym_idx   <= '0;
            r_samp_idx  <= '0;
            r_stop_pend <= 1'b0;
          end
        end

        ST_RUN: begin
          if (stop) r_stop_pend <= 1'b1;
          if (w_xfer) begin
            if (w_last_samp) begin
              r_samp_idx <= '0;
              if (w_last_sym) begin
                // End of frame: the frame is only counted once fully sent.
                r_sym_idx   <= '0;
                r_frame_cnt <= r_frame_cnt + 16'd1;
                if (r_stop_pend || stop) begin
                  r_state     <= ST_IDLE;
                  r_stop_pend <= 1'b0;
                end else if (gap_len > 0) begin
                  r_state   <= ST_GAP;
                  r_gap_cnt <= '0;
                end
              end else begin
                r_sym_idx <= r_sym_idx + SYM_W'(1);
              end
            end else begin
              r_samp_idx <= r_samp_idx + SAMP_W'(1);
            end
          end
        end

        ST_GAP: begin
          // The gap is a fixed number of cycles regardless of backpressure.
          if (stop) r_stop_pend <= 1'b1;
          if (r_gap_cnt == GAP_LAST) begin
            r_gap_cnt <= '0;
            if (r_stop_pend || stop) begin
              r_state     <= ST_IDLE;
              r_stop_pend <= 1'b0;
            end else begin
              r_state <= ST_RUN;
            end
          end else begin
            r_gap_cnt <= r_gap_cnt + GAP_W'(1);
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Outputs are pure decodes of registered state; markers are gated by ovalid.
  assign ovalid    = w_run;
  assign osos      = w_run && (r_samp_idx == '0);
  assign osop      = osos && (r_sym_idx == '0);
  assign ocp       = w_run && (r_samp_idx < CP_LEN);
  assign oeop      = w_run && w_last_samp && w_last_sym;
  assign sym_idx   = r_sym_idx;
  assign samp_idx  = r_samp_idx;
  assign frame_cnt = r_frame_cnt;
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_tx_frame_timer.sv
// tb_tx_frame_timer: drives two frame timers (no gap, gap of 3) with shared
// stimulus and scoreboards their per-cycle outputs against a flat
// frame-position reference model.
module tb_tx_frame_timer;

  localparam int N_SYMB  = 2;
  localparam int FFT     = 8;
  localparam int CP      = 2;
  localparam int N_SPFR  = FFT + CP;
  localparam int L_FRAME = N_SYMB * N_SPFR;
  localparam int SYM_W   = 1;
  localparam int SAMP_W  = 4;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_GAP  = 2;

  // Reference model: position within the frame as one flat sample number.
  typedef struct {
    int mode;
    int pos;
    int gap_left;
    int frames;
    bit pend;
    bit valid;
  } model_t;

  typedef struct packed {
    logic              ovalid;
    logic              osop;
    logic              osos;
    logic              ocp;
    logic              oeop;
    logic              busy;
    logic [SYM_W-1:0]  sym;
    logic [SAMP_W-1:0] samp;
    logic [15:0]       frames;
  } obs_t;

  logic clk = 1'b0;
  logic rst, start, stop, iready;

  logic              ov0, sop0, sos0, cp0, eop0, busy0;
  logic [SYM_W-1:0]  sym0;
  logic [SAMP_W-1:0] samp0;
  logic [15:0]       fc0;
  logic              ov3, sop3, sos3, cp3, eop3, busy3;
  logic [SYM_W-1:0]  sym3;
  logic [SAMP_W-1:0] samp3;
  logic [15:0]       fc3;

  int n_tests = 0;
  int n_fail  = 0;

  model_t m0, m3;
  obs_t   q0[$];
  obs_t   q3[$];

  always #5 clk = ~clk;

  tx_frame_timer #(.N_symb(N_SYMB), .fftsize(FFT), .cpsize(CP), .gap_len(0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .iready(iready),
    .ovalid(ov0), .osop(sop0), .osos(sos0), .ocp(cp0), .oeop(eop0),
    .sym_idx(sym0), .samp_idx(samp0), .frame_cnt(fc0), .busy(busy0)
  );

  tx_frame_timer #(.N_symb(N_SYMB), .fftsize(FFT), .cpsize(CP), .gap_len(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .iready(iready),
    .ovalid(ov3), .osop(sop3), .osos(sos3), .ocp(cp3), .oeop(eop3),
    .sym_idx(sym3), .samp_idx(samp3), .frame_cnt(fc3), .busy(busy3)
  );

  // Expected outputs for the current cycle, derived from the flat position.
  function automatic obs_t predict(model_t m);
    obs_t o;
    int   sym;
    int   samp;
    bit   v;
    v      = (m.mode == M_RUN);
    sym    = m.pos / N_SPFR;
    samp   = m.pos % N_SPFR;
    o.ovalid = v;
    o.osop   = v && (m.pos == 0);
    o.osos   = v && (samp == 0);
    o.ocp    = v && (samp < CP);
    o.oeop   = v && (m.pos == L_FRAME - 1);
    o.busy   = (m.mode != M_IDLE);
    o.sym    = SYM_W'(sym);
    o.samp   = SAMP_W'(samp);
    o.frames = 16'(m.frames);
    return o;
  endfunction

  // Advance the model by one clock edge given the inputs held during the cycle.
  function automatic model_t step(model_t m, bit r, bit s, bit p, bit y, int gap);
    model_t n;
    n = m;
    if (r) begin
      n = '{mode: M_IDLE, pos: 0, gap_left: 0, frames: 0, pend: 1'b0, valid: 1'b1};
      return n;
    end
    case (m.mode)
      M_IDLE: begin
        if (s) begin
          n.mode = M_RUN;
          n.pos  = 0;
          n.pend = 1'b0;
        end
      end
      M_RUN: begin
        if (p) n.pend = 1'b1;
        if (y) begin
          if (m.pos == L_FRAME - 1) begin
            n.pos    = 0;
            n.frames = (m.frames + 1) % 65536;
            if (n.pend) begin
              n.mode = M_IDLE;
              n.pend = 1'b0;
            end else if (gap > 0) begin
              n.mode     = M_GAP;
              n.gap_left = gap;
            end
          end else begin
            n.pos = m.pos + 1;
          end
        end
      end
      default: begin
        if (p) n.pend = 1'b1;
        n.gap_left = m.gap_left - 1;
        if (n.gap_left == 0) begin
          if (n.pend) begin
            n.mode = M_IDLE;
            n.pend = 1'b0;
          end else begin
            n.mode = M_RUN;
          end
        end
      end
    endcase
    return n;
  endfunction

  task automatic check(input string name, input obs_t act, input obs_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: actual v/sop/sos/cp/eop/busy=%b%b%b%b%b%b sym=%0d samp=%0d fc=%0d, expected v/sop/sos/cp/eop/busy=%b%b%b%b%b%b sym=%0d samp=%0d fc=%0d",
               name, $time,
               act.ovalid, act.osop, act.osos, act.ocp, act.oeop, act.busy, act.sym, act.samp, act.frames,
               exp.ovalid, exp.osop, exp.osos, exp.ocp, exp.oeop, exp.busy, exp.sym, exp.samp, exp.frames);
    end
  endtask

  // One cycle of stimulus: apply inputs, queue the expected outputs of this
  // cycle, then let the edge happen and advance the models.
  task automatic drive(input bit r, input bit s, input bit p, input bit y);
    rst = r; start = s; stop = p; iready = y;
    if (m0.valid) q0.push_back(predict(m0));
    if (m3.valid) q3.push_back(predict(m3));
    @(posedge clk);
    m0 = step(m0, r, s, p, y, 0);
    m3 = step(m3, r, s, p, y, 3);
    #1;
  endtask

  // Monitor: pops one expected record per DUT each cycle, away from the edge.
  always @(negedge clk) begin
    obs_t a;
    if (q0.size() > 0) begin
      a = '{ov0, sop0, sos0, cp0, eop0, busy0, sym0, samp0, fc0};
      check("gap0_outputs", a, q0.pop_front());
    end
    if (q3.size() > 0) begin
      a = '{ov3, sop3, sos3, cp3, eop3, busy3, sym3, samp3, fc3};
      check("gap3_outputs", a, q3.pop_front());
    end
  end

  initial begin
    m0 = '{mode: M_IDLE, pos: 0, gap_left: 0, frames: 0, pend: 1'b0, valid: 1'b0};
    m3 = m0;

    // Reset.
    drive(1, 0, 0, 1);
    drive(1, 0, 0, 1);

    // Free run: start pulse, iready held high for three frames.
    drive(0, 1, 0, 1);
    for (int i = 0; i < 65; i++) drive(0, 0, 0, 1);

    // Backpressure: random iready, with stray start pulses that must be ignored.
    for (int i = 0; i < 150; i++)
      drive(0, ($urandom_range(0, 15) == 0), 0, $urandom_range(0, 1));

    // Graceful stop at sample 5 of a fresh frame, then restart.
    drive(1, 0, 0, 1);
    drive(0, 1, 0, 1);
    for (int i = 0; i < 5; i++) drive(0, 0, 0, 1);
    drive(0, 0, 1, 1);
    for (int i = 0; i < 40; i++) drive(0, 0, 0, $urandom_range(0, 1));
    drive(0, 1, 0, 1);
    for (int i = 0; i < 25; i++) drive(0, 0, 0, 1);

    // Reset at sample 13, then start and stop together in IDLE.
    drive(1, 0, 0, 1);
    drive(0, 1, 0, 1);
    for (int i = 0; i < 13; i++) drive(0, 0, 0, 1);
    drive(1, 0, 0, 1);
    drive(0, 1, 1, 1);
    for (int i = 0; i < 30; i++) drive(0, 0, 0, 1);

    // Stop landing exactly on the end-of-frame transfer.
    drive(1, 0, 0, 1);
    drive(0, 1, 0, 1);
    for (int i = 0; i < 19; i++) drive(0, 0, 0, 1);
    drive(0, 0, 1, 1);
    for (int i = 0; i < 8; i++) drive(0, 0, 0, 1);

    // Mixed random traffic, including rare resets.
    for (int i = 0; i < 400; i++)
      drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 19) == 0),
            ($urandom_range(0, 29) == 0), ($urandom_range(0, 3) != 0));

    // Frame counter wrap: preload 65535 while idle, run one frame.
    drive(1, 0, 0, 1);
    force u_dut0.r_frame_cnt = 16'hFFFF;
    force u_dut3.r_frame_cnt = 16'hFFFF;
    m0.frames = 65535;
    m3.frames = 65535;
    #1;
    release u_dut0.r_frame_cnt;
    release u_dut3.r_frame_cnt;
    drive(0, 0, 0, 1);
    drive(0, 1, 0, 1);
    for (int i = 0; i < 30; i++) drive(0, 0, 0, 1);

    @(negedge clk);
    #1;
    n_tests++;
    if (q0.size() != 0 || q3.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: actual %0d/%0d entries left, expected 0/0", q0.size(), q3.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
